// File: rtl/shadow_chain_rx.sv
// shadow_chain_rx: dump-chain receiver, deserialises ch_in into WORD_W words + FIFO.
// Optional idle timeout in RECV enabled by SHADOW_RX_TIMEOUT_EN.
module shadow_chain_rx #(
  parameter int WORD_W      = 32,
  parameter int FIFO_DEPTH  = 8,
  parameter int FRAME_BITS  = 38,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              sh_clk,
  input  logic              sh_rst_l,
  input  logic              start,
  output logic              dump_en,
  input  logic              ch_in,
  input  logic              ch_in_vld,
  input  logic              ch_in_done,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_vld,
  input  logic              rd_rdy,
  output logic              busy,
  output logic              frame_done,
  output logic [15:0]       bit_cnt,
  output logic              len_err,
  output logic              ovf,
  output logic              tmo
);

  localparam int FW = $clog2(WORD_W);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RECV,
    S_FLUSH
  } st_e;

  st_e               st_q;
  logic [FW-1:0]     fill_q;
  logic [WORD_W-1:0] sh_q;
  logic [15:0]       cnt_q;
  logic              dump_q;
  logic              busy_q;
  logic              fd_q;
  logic              len_err_q;
  logic              ovf_q;
  logic              tmo_q;

  logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]       wp_q;
  logic [AW:0]       rp_q;

  logic              bit_take;
  logic              last_bit;
  logic [WORD_W-1:0] word_d;
  logic              push;
  logic [WORD_W-1:0] push_data;
  logic              empty;
  logic              full;
  logic              pop;
  logic              wr_ok;
  logic              drop;
  logic              tmo_hit;

`ifdef SHADOW_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_q;

  assign tmo_hit = (st_q == S_RECV) && !ch_in_vld && !ch_in_done &&
                   (to_q == TW'(TIMEOUT_CYC - 1));

  // Idle-cycle counter, restarted on entry to RECV and on every valid bit
  always_ff @(posedge sh_clk or negedge sh_rst_l) begin
    if (!sh_rst_l) begin
      to_q <= '0;
    end else if (st_q != S_RECV || ch_in_vld) begin
      to_q <= '0;
    end else begin
      to_q <= to_q + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  assign bit_take  = (st_q == S_RECV) && ch_in_vld;
  assign last_bit  = (fill_q == FW'(WORD_W - 1));
  assign word_d    = sh_q | (WORD_W'(ch_in) << fill_q);
  assign push      = (bit_take && last_bit) ||
                     ((st_q == S_FLUSH) && (fill_q != '0));
  assign push_data = (st_q == S_FLUSH) ? sh_q : word_d;

  assign empty = (wp_q == rp_q);
  assign full  = ((wp_q - rp_q) == (AW+1)'(FIFO_DEPTH));
  assign pop   = rd_rdy && !empty;
  assign wr_ok = push && (!full || pop);
  assign drop  = push && full && !pop;

  assign rd_vld     = !empty;
  assign rd_data    = empty ? '0 : mem_q[rp_q[AW-1:0]];
  assign dump_en    = dump_q;
  assign busy       = busy_q;
  assign frame_done = fd_q;
  assign bit_cnt    = cnt_q;
  assign len_err    = len_err_q;
  assign ovf        = ovf_q;
  assign tmo        = tmo_q;

  // Frame sequencing and all status outputs
  always_ff @(posedge sh_clk or negedge sh_rst_l) begin
    if (!sh_rst_l) begin
      st_q      <= S_IDLE;
      dump_q    <= 1'b0;
      busy_q    <= 1'b0;
      fd_q      <= 1'b0;
      cnt_q     <= '0;
      len_err_q <= 1'b0;
      ovf_q     <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      dump_q <= 1'b0;
      fd_q   <= 1'b0;
      if (drop) ovf_q <= 1'b1;
      unique case (st_q)
        S_IDLE: begin
          if (start) begin
            st_q      <= S_REQ;
            dump_q    <= 1'b1;
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            len_err_q <= 1'b0;
            ovf_q     <= 1'b0;
            tmo_q     <= 1'b0;
          end
        end
        S_REQ: st_q <= S_RECV;
        S_RECV: begin
          if (ch_in_vld && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
          if (ch_in_done || tmo_hit) st_q <= S_FLUSH;
          if (tmo_hit) tmo_q <= 1'b1;
        end
        S_FLUSH: begin
          len_err_q <= (cnt_q != 16'(FRAME_BITS));
          fd_q      <= 1'b1;
          busy_q    <= 1'b0;
          st_q      <= S_IDLE;
        end
        default: st_q <= S_IDLE;
      endcase
    end
  end

  // Word assembly: LSB-first shift-in, cleared on every push
  always_ff @(posedge sh_clk or negedge sh_rst_l) begin
    if (!sh_rst_l) begin
      fill_q <= '0;
      sh_q   <= '0;
    end else if (st_q == S_FLUSH) begin
      fill_q <= '0;
      sh_q   <= '0;
    end else if (bit_take) begin
      if (last_bit) begin
        fill_q <= '0;
        sh_q   <= '0;
      end else begin
        fill_q <= fill_q + 1'b1;
        sh_q   <= word_d;
      end
    end
  end

  // FIFO pointers; extra MSB distinguishes full from empty
  always_ff @(posedge sh_clk or negedge sh_rst_l) begin
    if (!sh_rst_l) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (wr_ok) wp_q <= wp_q + 1'b1;
      if (pop)   rp_q <= rp_q + 1'b1;
    end
  end

  // FIFO storage; contents are don't-care while the pointers say empty
  always_ff @(posedge sh_clk) begin
    if (wr_ok) mem_q[wp_q[AW-1:0]] <= push_data;
  end

endmodule

// File: tb/tb_shadow_chain_rx.sv
// tb_shadow_chain_rx: randomized self-checking bench for shadow_chain_rx.
// Expected words come from packing the sent bit list into 32-bit words.
module tb_shadow_chain_rx;

  typedef bit bitq_t[$];
  typedef logic [31:0] wq_t[$];

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, ch_in, ch_in_vld, ch_in_done, rd_rdy;
  logic        dump_en, rd_vld, busy, frame_done, len_err, ovf, tmo;
  logic [31:0] rd_data;
  logic [15:0] bit_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int rdmode = 0;
  int dump_cnt = 0;
  int fd_cnt = 0;
  wq_t got;

  always #5 clk = ~clk;

  shadow_chain_rx #(
    .WORD_W(32), .FIFO_DEPTH(8), .FRAME_BITS(38), .TIMEOUT_CYC(16)
  ) dut (
    .sh_clk(clk), .sh_rst_l(rst_n), .start(start), .dump_en(dump_en),
    .ch_in(ch_in), .ch_in_vld(ch_in_vld), .ch_in_done(ch_in_done),
    .rd_data(rd_data), .rd_vld(rd_vld), .rd_rdy(rd_rdy), .busy(busy),
    .frame_done(frame_done), .bit_cnt(bit_cnt), .len_err(len_err),
    .ovf(ovf), .tmo(tmo)
  );

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic wq_t pack(bitq_t b);
    wq_t w;
    logic [31:0] acc = '0;
    int n = 0;
    foreach (b[i]) begin
      acc[n] = b[i];
      n++;
      if (n == 32) begin
        w.push_back(acc);
        acc = '0;
        n = 0;
      end
    end
    if (n > 0) w.push_back(acc);
    return w;
  endfunction

  function automatic bitq_t rand_bits(int n);
    bitq_t b;
    for (int i = 0; i < n; i++) b.push_back(bit'($urandom_range(1, 0)));
    return b;
  endfunction

  task automatic cyc();
    rd_rdy = (rdmode == 1) || (rdmode == 2 && $urandom_range(1, 0) == 1);
    if (rd_rdy && rd_vld) got.push_back(rd_data);
    @(posedge clk);
    #1;
    if (dump_en) dump_cnt++;
    if (frame_done) fd_cnt++;
    start = 1'b0;
    ch_in_vld = 1'b0;
    ch_in_done = 1'b0;
    ch_in = 1'($urandom_range(1, 0));
  endtask

  task automatic drain();
    rdmode = 1;
    repeat (12) cyc();
    rdmode = 0;
  endtask

  task automatic send(bitq_t b, int maxgap, bit done_last, int late);
    dump_cnt = 0;
    fd_cnt = 0;
    start = 1'b1;
    cyc();
    ch_in_vld = 1'b1;
    cyc();
    foreach (b[i]) begin
      repeat ($urandom_range(maxgap, 0)) cyc();
      ch_in_vld = 1'b1;
      ch_in = b[i];
      ch_in_done = done_last && (i == b.size() - 1);
      cyc();
    end
    if (!done_last || b.size() == 0) begin
      repeat (late) cyc();
      ch_in_done = 1'b1;
      cyc();
    end
    cyc();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 0; ch_in = 0; ch_in_vld = 0; ch_in_done = 0; rd_rdy = 0;
    #1;
    n_cmp++;
    if ({dump_en, rd_vld, busy, frame_done, len_err, ovf, tmo} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 0000000",
               {dump_en, rd_vld, busy, frame_done, len_err, ovf, tmo});
    end
    n_cmp++;
    if (rd_data !== 32'h0 || bit_cnt !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_data: got rd_data=%h bit_cnt=%h want 0", rd_data, bit_cnt);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc();
    cyc();
    n_cmp++;
    if ({dump_en, rd_vld, busy, frame_done, ovf, tmo} !== 6'b0) begin
      n_bad++;
      $display("FAIL idle_after_reset: got %b want 000000",
               {dump_en, rd_vld, busy, frame_done, ovf, tmo});
    end
  endtask

  task automatic test_all_ones();
    bitq_t b;
    for (int i = 0; i < 38; i++) b.push_back(1'b1);
    rdmode = 0;
    send(b, 0, 1'b1, 0);
    n_cmp++;
    if (dump_cnt !== 1) begin
      n_bad++; $display("FAIL ones_dump_en: got %0d pulses want 1", dump_cnt);
    end
    n_cmp++;
    if (fd_cnt !== 1) begin
      n_bad++; $display("FAIL ones_frame_done: got %0d pulses want 1", fd_cnt);
    end
    n_cmp++;
    if (bit_cnt !== 16'd38 || len_err !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL ones_status: got cnt=%0d len_err=%b busy=%b want 38 0 0",
               bit_cnt, len_err, busy);
    end
    got.delete();
    drain();
    n_cmp++;
    if (got.size() != 2) begin
      n_bad++; $display("FAIL ones_words: got %0d words want 2", got.size());
    end else if (got[0] !== 32'hFFFF_FFFF || got[1] !== 32'h0000_003F) begin
      n_bad++;
      $display("FAIL ones_words: got %h %h want ffffffff 0000003f", got[0], got[1]);
    end
  endtask

  task automatic test_pattern32();
    bitq_t b;
    logic [31:0] p = 32'hA5A5_0F0F;
    for (int i = 0; i < 32; i++) b.push_back(p[i]);
    rdmode = 0;
    send(b, 0, 1'b0, 2);
    n_cmp++;
    if (bit_cnt !== 16'd32 || len_err !== 1'b1) begin
      n_bad++;
      $display("FAIL pat_status: got cnt=%0d len_err=%b want 32 1", bit_cnt, len_err);
    end
    got.delete();
    drain();
    n_cmp++;
    if (got.size() != 1) begin
      n_bad++; $display("FAIL pat_words: got %0d words want 1", got.size());
    end else if (got[0] !== 32'hA5A5_0F0F) begin
      n_bad++; $display("FAIL pat_words: got %h want a5a50f0f", got[0]);
    end
  endtask

  task automatic test_overflow();
    bitq_t b = rand_bits(288);
    wq_t exp = pack(b);
    rdmode = 0;
    send(b, 1, 1'b1, 0);
    n_cmp++;
    if (ovf !== 1'b1 || rd_vld !== 1'b1) begin
      n_bad++; $display("FAIL ovf_set: got ovf=%b rd_vld=%b want 1 1", ovf, rd_vld);
    end
    got.delete();
    drain();
    n_cmp++;
    if (got.size() != 8) begin
      n_bad++; $display("FAIL ovf_kept: got %0d words want 8", got.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (got[i] !== exp[i]) begin
          n_bad++; $display("FAIL ovf_word%0d: got %h want %h", i, got[i], exp[i]);
        end
      end
    end
    start = 1'b1;
    cyc();
    n_cmp++;
    if (ovf !== 1'b0 || len_err !== 1'b0 || bit_cnt !== 16'd0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_clear: got ovf=%b len_err=%b cnt=%0d busy=%b want 0 0 0 1",
               ovf, len_err, bit_cnt, busy);
    end
    cyc();
    ch_in_done = 1'b1;
    cyc();
    cyc();
    n_cmp++;
    if (rd_vld !== 1'b0 || len_err !== 1'b1 || bit_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL empty_frame: got rd_vld=%b len_err=%b cnt=%0d want 0 1 0",
               rd_vld, len_err, bit_cnt);
    end
  endtask

  task automatic test_full_pop();
    bitq_t b = rand_bits(288);
    wq_t exp = pack(b);
    rdmode = 0;
    got.delete();
    start = 1'b1;
    cyc();
    cyc();
    for (int i = 0; i < 288; i++) begin
      ch_in_vld = 1'b1;
      ch_in = b[i];
      ch_in_done = (i == 287);
      rdmode = (i == 287) ? 1 : 0;
      cyc();
    end
    rdmode = 0;
    cyc();
    cyc();
    n_cmp++;
    if (ovf !== 1'b0 || got.size() != 1) begin
      n_bad++;
      $display("FAIL fullpop_ovf: got ovf=%b popped=%0d want 0 1", ovf, got.size());
    end
    drain();
    n_cmp++;
    if (got.size() != 9) begin
      n_bad++; $display("FAIL fullpop_words: got %0d words want 9", got.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        n_cmp++;
        if (got[i] !== exp[i]) begin
          n_bad++; $display("FAIL fullpop_word%0d: got %h want %h", i, got[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_start_ignored_reset();
    bitq_t pre = rand_bits(64);
    bitq_t b = rand_bits(20);
    bitq_t post = rand_bits(40);
    wq_t exp = pack(post);
    rdmode = 0;
    send(pre, 0, 1'b1, 0);
    dump_cnt = 0;
    fd_cnt = 0;
    start = 1'b1;
    cyc();
    cyc();
    for (int i = 0; i < 20; i++) begin
      ch_in_vld = 1'b1;
      ch_in = b[i];
      start = (i == 5 || i == 15);
      cyc();
    end
    n_cmp++;
    if (dump_cnt !== 1 || busy !== 1'b1 || bit_cnt !== 16'd20) begin
      n_bad++;
      $display("FAIL start_ignored: got dump=%0d busy=%b cnt=%0d want 1 1 20",
               dump_cnt, busy, bit_cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({dump_en, rd_vld, busy, frame_done, len_err, ovf, tmo} !== 7'b0 ||
        rd_data !== 32'h0 || bit_cnt !== 16'h0) begin
      n_bad++;
      $display("FAIL async_reset: got flags=%b data=%h cnt=%h want 0",
               {dump_en, rd_vld, busy, frame_done, len_err, ovf, tmo}, rd_data, bit_cnt);
    end
    cyc();
    cyc();
    rst_n = 1'b1;
    repeat (3) cyc();
    n_cmp++;
    if (fd_cnt !== 0 || rd_vld !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_discard: got fd=%0d rd_vld=%b want 0 0", fd_cnt, rd_vld);
    end
    got.delete();
    send(post, 0, 1'b1, 0);
    drain();
    n_cmp++;
    if (got.size() != exp.size()) begin
      n_bad++;
      $display("FAIL post_reset_words: got %0d want %0d", got.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        n_cmp++;
        if (got[i] !== exp[i]) begin
          n_bad++; $display("FAIL post_reset_word%0d: got %h want %h", i, got[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 20; f++) begin
      int len = ($urandom_range(3, 0) == 0) ? 38 : $urandom_range(250, 0);
      bitq_t b = rand_bits(len);
      wq_t exp = pack(b);
      bit dl = bit'($urandom_range(1, 0));
      got.delete();
      rdmode = 2;
      send(b, 2, dl, $urandom_range(3, 0));
      n_cmp++;
      if (bit_cnt !== 16'(len) || len_err !== (len != 38)) begin
        n_bad++;
        $display("FAIL rnd%0d_status: got cnt=%0d len_err=%b want %0d %b",
                 f, bit_cnt, len_err, len, (len != 38));
      end
      n_cmp++;
      if (dump_cnt !== 1 || fd_cnt !== 1 || ovf !== 1'b0 || tmo !== 1'b0) begin
        n_bad++;
        $display("FAIL rnd%0d_pulses: got dump=%0d fd=%0d ovf=%b tmo=%b want 1 1 0 0",
                 f, dump_cnt, fd_cnt, ovf, tmo);
      end
      drain();
      n_cmp++;
      if (got.size() != exp.size()) begin
        n_bad++;
        $display("FAIL rnd%0d_count: got %0d words want %0d", f, got.size(), exp.size());
      end else begin
        for (int i = 0; i < exp.size(); i++) begin
          n_cmp++;
          if (got[i] !== exp[i]) begin
            n_bad++;
            $display("FAIL rnd%0d_word%0d: got %h want %h", f, i, got[i], exp[i]);
          end
        end
      end
    end
  endtask

`ifdef SHADOW_RX_TIMEOUT_EN
  task automatic test_timeout();
    bitq_t b = rand_bits(5);
    wq_t exp = pack(b);
    int k = 0;
    rdmode = 0;
    got.delete();
    start = 1'b1;
    cyc();
    cyc();
    foreach (b[i]) begin
      ch_in_vld = 1'b1;
      ch_in = b[i];
      cyc();
    end
    while (tmo !== 1'b1 && k < 40) begin
      cyc();
      k++;
    end
    n_cmp++;
    if (k != 16) begin
      n_bad++; $display("FAIL tmo_delay: got %0d idle cycles want 16", k);
    end
    cyc();
    cyc();
    n_cmp++;
    if (tmo !== 1'b1 || len_err !== 1'b1 || busy !== 1'b0 || bit_cnt !== 16'd5) begin
      n_bad++;
      $display("FAIL tmo_status: got tmo=%b len_err=%b busy=%b cnt=%0d want 1 1 0 5",
               tmo, len_err, busy, bit_cnt);
    end
    drain();
    n_cmp++;
    if (got.size() != 1) begin
      n_bad++; $display("FAIL tmo_word: got %0d words want 1", got.size());
    end else if (got[0] !== exp[0]) begin
      n_bad++; $display("FAIL tmo_word: got %h want %h", got[0], exp[0]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_all_ones();
    test_pattern32();
    test_overflow();
    test_full_pop();
    test_start_ignored_reset();
    test_random();
`ifdef SHADOW_RX_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
